// File: rtl/hamming_stream_acc.sv
// hamming_stream_acc
// ------------------
// Frame-based Hamming distance accumulator. Each accepted beat compares W bits
// of x against W bits of y and adds popcount(x ^ y) to a running sum. After CC
// accepted beats the frame completes: o carries the sum, o_valid pulses for one
// cycle and match reports whether the sum is <= the threshold captured at start.
// Beats are qualified by in_valid, so the upstream sequencer may stall freely.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     begin a new frame (accepted in IDLE or DONE, ignored while busy)
//   in_valid  x/y beat present this cycle (only meaningful while busy)
//   x, y      W-bit operand beats
//   thr       OW-bit threshold, captured when start is accepted
//   busy      frame in progress
//   o         last completed frame distance (held until the next frame completes)
//   o_valid   one-cycle pulse in the cycle after the last beat is accepted
//   match     o <= captured threshold, held alongside o

module hamming_stream_acc #(
  parameter int W  = 8,
  parameter int CC = 200,
  parameter int OW = $clog2(W*CC+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [OW-1:0] thr,
  output logic          busy,
  output logic [OW-1:0] o,
  output logic          o_valid,
  output logic          match
);

  localparam int PW = $clog2(W+1);
  // A one-beat frame still needs a 1-bit counter to keep the compare well formed.
  localparam int CW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(CC-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] acc;
  logic [OW-1:0] thr_q;
  logic [CW-1:0] beat_cnt;
  logic [PW-1:0] pc;
  logic [OW-1:0] sum;
  logic          beat;
  logic          last_beat;
  logic          start_ok;

  function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
    logic [PW-1:0] cnt;
    // NOTE: inside a combinational function, blocking '=' is correct; each
    // iteration must see the count produced by the previous one.
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(v[i]);
    end
    return cnt;
  endfunction

  // x/y only reach the accumulator through 'beat', so their value during a
  // stall (or outside ACC) never disturbs the sum.
  assign pc        = popcount(x ^ y);
  assign sum       = acc + OW'(pc);
  assign beat      = (state == ACC) && in_valid;
  assign last_beat = beat && (beat_cnt == LAST_BEAT);
  assign start_ok  = start && (state != ACC);

  assign busy    = (state == ACC);
  assign o_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case guarantees every path drives
    // state_nxt, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = start ? ACC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: accumulator, beat counter, captured threshold and held result.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all of these are plain registers (no RAM), so every one gets an
    // explicit reset value; a mid-frame reset therefore leaves no stale sum.
    if (!rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      thr_q    <= '0;
      o        <= '0;
      match    <= 1'b0;
    end else begin
      if (start_ok) begin
        // The beat presented in the start cycle is deliberately not counted.
        acc      <= '0;
        beat_cnt <= '0;
        thr_q    <= thr;
      end else if (beat) begin
        acc      <= sum;
        beat_cnt <= beat_cnt + CW'(1);
      end
      // o/match change only on the edge that enters DONE, then hold.
      if (last_beat) begin
        o     <= sum;
        match <= (sum <= thr_q);
      end
    end
  end

endmodule

// File: tb/tb_hamming_stream_acc.sv
// tb_hamming_stream_acc
// ---------------------
// Drives two instances: a short-frame one (W=8, CC=4) for the directed
// scenarios and a default-parameter one (W=8, CC=200) for randomized frames.
// Expected sums come from $countones over the beats the bench itself issued.
// Inputs are driven and outputs sampled at the falling clock edge.

module tb_hamming_stream_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        start;
  logic        in_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [10:0] thr;

  logic        s_busy, s_ov, s_match;
  logic [5:0]  s_o;
  logic        l_busy, l_ov, l_match;
  logic [10:0] l_o;

  logic        s_start, s_iv, l_start, l_iv;
  logic        obs_busy, obs_ov, obs_match;
  logic [10:0] obs_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] last_o;
  logic        last_match;

  always #5 clk = ~clk;

  assign s_start   = start    && !sel;
  assign s_iv      = in_valid && !sel;
  assign l_start   = start    &&  sel;
  assign l_iv      = in_valid &&  sel;
  assign obs_busy  = sel ? l_busy  : s_busy;
  assign obs_ov    = sel ? l_ov    : s_ov;
  assign obs_match = sel ? l_match : s_match;
  assign obs_o     = sel ? l_o     : {5'b0, s_o};

  hamming_stream_acc #(.W(8), .CC(4)) u_small (
    .clk      (clk),
    .rst      (rst),
    .start    (s_start),
    .in_valid (s_iv),
    .x        (x),
    .y        (y),
    .thr      (thr[5:0]),
    .busy     (s_busy),
    .o        (s_o),
    .o_valid  (s_ov),
    .match    (s_match)
  );

  hamming_stream_acc u_large (
    .clk      (clk),
    .rst      (rst),
    .start    (l_start),
    .in_valid (l_iv),
    .x        (x),
    .y        (y),
    .thr      (thr),
    .busy     (l_busy),
    .o        (l_o),
    .o_valid  (l_ov),
    .match    (l_match)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_o_hold"},     32'(obs_o),     32'(last_o));
    check({tag, "_match_hold"}, 32'(obs_match), 32'(last_match));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  32'(obs_busy),  32'd0);
    check({tag, "_ov"},    32'(obs_ov),    32'd0);
    check({tag, "_o"},     32'(obs_o),     32'd0);
    check({tag, "_match"}, 32'(obs_match), 32'd0);
  endtask

  // Idle cycles with junk beats on in_valid=1: nothing may start or accumulate.
  task automatic idle(input int n);
    repeat (n) begin
      start    = 1'b0;
      in_valid = 1'b1;
      x        = 8'($urandom);
      y        = 8'($urandom);
      @(negedge clk);
      check("idle_busy", 32'(obs_busy), 32'd0);
      check("idle_ov",   32'(obs_ov),   32'd0);
      check_hold("idle");
    end
  endtask

  // One full frame, starting at the current falling edge (this may be the
  // DONE cycle of the previous frame). stall >= 0: that many in_valid=0 cycles
  // before every beat; stall < 0: random 0..3. poke drives random start pulses
  // while the frame is in progress.
  task automatic frame(input logic [10:0] thr_v, input logic [7:0] fx, input logic [7:0] fy,
                       input bit rnd, input int stall, input bit poke);
    int  cc;
    int  exp_sum;
    int  ns;
    bit  exp_match;
    cc      = sel ? 200 : 4;
    exp_sum = 0;
    // Start cycle carries a differing beat that must not be counted.
    start    = 1'b1;
    thr      = thr_v;
    in_valid = 1'b1;
    x        = 8'hFF;
    y        = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(obs_busy), 32'd1);
    check("start_ov",   32'(obs_ov),   32'd0);
    check_hold("start");
    for (int b = 0; b < cc; b++) begin
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      repeat (ns) begin
        in_valid = 1'b0;
        x        = 8'hFF;
        y        = 8'h00;
        start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check("stall_busy", 32'(obs_busy), 32'd1);
        check("stall_ov",   32'(obs_ov),   32'd0);
      end
      in_valid = 1'b1;
      x        = rnd ? 8'($urandom) : fx;
      y        = rnd ? 8'($urandom) : fy;
      start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_sum += $countones(x ^ y);
      @(negedge clk);
      if (b < cc - 1) begin
        check("acc_busy", 32'(obs_busy), 32'd1);
        check("acc_ov",   32'(obs_ov),   32'd0);
        check_hold("acc");
      end else begin
        exp_match = (exp_sum <= int'(thr_v));
        check("done_ov",    32'(obs_ov),    32'd1);
        check("done_busy",  32'(obs_busy),  32'd0);
        check("done_o",     32'(obs_o),     32'(exp_sum));
        check("done_match", 32'(obs_match), 32'(exp_match));
        last_o     = 11'(exp_sum);
        last_match = exp_match;
      end
    end
    // Still in the DONE cycle: junk beat must be ignored, start is up to caller.
    start    = 1'b0;
    in_valid = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    sel        = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    x          = '0;
    y          = '0;
    thr        = '0;
    last_o     = '0;
    last_match = 1'b0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    check_reset("rst_small");
    sel = 1'b1;
    #1;
    check_reset("rst_large");
    sel = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);

    // Equal operands: zero distance, match against thr=0.
    idle(2);
    frame(11'd0, 8'hA5, 8'hA5, 1'b0, 0, 1'b0);

    // All differ (32 > 16), nibble swap (32), single bit (4 <= 16).
    idle(1);
    frame(11'd16, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    idle(1);
    frame(11'd16, 8'hF0, 8'h0F, 1'b0, 0, 1'b0);
    idle(1);
    frame(11'd16, 8'h01, 8'h00, 1'b0, 0, 1'b0);

    // Stalls carrying all-differ data; only valid beats (4 bits each) count.
    idle(1);
    frame(11'd20, 8'h3C, 8'h00, 1'b0, 3, 1'b0);

    // start pulses during ACC, then a restart in the DONE cycle whose beat
    // (FF vs 00) must not be counted.
    idle(2);
    frame(11'd10, 8'h0F, 8'h01, 1'b0, -1, 1'b1);
    frame(11'd40, 8'hAA, 8'h55, 1'b0, 0, 1'b0);

    // Asynchronous reset two beats into a frame, away from any clock edge.
    idle(1);
    start    = 1'b1;
    thr      = 11'd5;
    in_valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    x        = 8'hFF;
    y        = 8'h00;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check_reset("async_rst");
    last_o     = '0;
    last_match = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    frame(11'd5, 8'h11, 8'h00, 1'b0, 0, 1'b0);

    // Default parameters: random frames with random stalls and start pokes.
    sel = 1'b1;
    #1;
    last_o     = '0;
    last_match = 1'b0;
    idle(2);
    for (int f = 0; f < 50; f++) begin
      frame(11'(700 + $urandom_range(0, 200)), 8'h00, 8'h00, 1'b1, -1, 1'(f % 2));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    // Maximum distance 1600, at and just below the threshold boundary.
    idle(1);
    frame(11'd1600, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    frame(11'd1599, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
